// File: rtl/egress_readback_pkg.sv
// egress_readback_pkg: shared port count, register map and STATUS layout
package egress_readback_pkg;
  localparam int NUM_PORTS = 3;
  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_POP1 = 3'd1;
  localparam logic [2:0] ADDR_POP2 = 3'd2;
  localparam logic [2:0] ADDR_POP3 = 3'd3;
  localparam logic [2:0] ADDR_OCC1 = 3'd4;
  localparam logic [2:0] ADDR_OCC2 = 3'd5;
  localparam logic [2:0] ADDR_OCC3 = 3'd6;
  localparam logic [2:0] ADDR_DROPS = 3'd7;
  typedef struct packed {
    logic unf;
    logic ovf;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] nonempty;
  } status_t;
endpackage

// File: rtl/egress_readback_if.sv
// egress_readback_if: Avalon read slave plus switch egress byte lanes
interface egress_readback_if;
  import egress_readback_pkg::*;
  logic chipselect_i;
  logic read_i;
  logic [2:0] address_i;
  logic [7:0] readdata_o;
  logic [NUM_PORTS-1:0] eg_valid_i;
  logic [NUM_PORTS-1:0][7:0] eg_data_i;
  logic eg_irq_o;
  modport master (output chipselect_i, read_i, address_i, eg_valid_i, eg_data_i, input readdata_o, eg_irq_o);
  modport slave (input chipselect_i, read_i, address_i, eg_valid_i, eg_data_i, output readdata_o, eg_irq_o);
endinterface

// File: rtl/egress_readback_fifo.sv
// egress_readback_fifo: DEPTH x 8 show-ahead queue with same-cycle push and pop
module egress_readback_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o,
  output logic [AW:0] count_o,
  output logic full_o,
  output logic empty_o
);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  // storage; a push into a full queue overwrites the head only after it is read out this cycle
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= din_i;
  // pointers wrap naturally at DEPTH; callers never push when full without popping
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(push_i);
      rd_q <= rd_q + AW'(pop_i);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  assign dout_o = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/egress_readback.sv
// egress_readback: captures switch egress bytes into per-port queues and serves host reads
module egress_readback
  import egress_readback_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  egress_readback_if.slave bus
);
  logic [NUM_PORTS-1:0] sel, push, pop, full, empty, drop;
  logic [NUM_PORTS-1:0][7:0] head;
  logic [NUM_PORTS-1:0][AW:0] cnt;
  logic rd, is_pop, is_occ, unf_set, clr_st, clr_dr;
  logic [1:0] pi, ndrops;
  logic [7:0] pop_byte, rdata_d, rdata_q, drop_d, drop_q;
  logic [AW:0] occ;
  logic [8:0] drop_sum;
  logic unf_d, unf_q, ovf_d, ovf_q, irq_q;
  status_t st;
  assign rd = bus.chipselect_i && bus.read_i;
  assign is_pop = bus.address_i inside {ADDR_POP1, ADDR_POP2, ADDR_POP3};
  assign is_occ = bus.address_i inside {ADDR_OCC1, ADDR_OCC2, ADDR_OCC3};
  assign pi = bus.address_i[2] ? bus.address_i[1:0] : bus.address_i[1:0] - 2'd1;
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign sel[p] = pi == 2'(p);
    assign pop[p] = rd && is_pop && sel[p] && !empty[p];
    assign push[p] = bus.eg_valid_i[p] && (!full[p] || pop[p]);
    assign drop[p] = bus.eg_valid_i[p] && !push[p];
    egress_readback_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push_i(push[p]), .pop_i(pop[p]), .din_i(bus.eg_data_i[p]),
      .dout_o(head[p]), .count_o(cnt[p]), .full_o(full[p]), .empty_o(empty[p])
    );
  end
  // register decode, sticky flag and drop-counter next state; set events beat clears
  always_comb begin
    pop_byte = 8'h00;
    occ = '0;
    for (int k = 0; k < NUM_PORTS; k++)
      if (sel[k]) begin
        pop_byte = empty[k] ? 8'h00 : head[k];
        occ = cnt[k];
      end
    st = {unf_q, ovf_q, full, ~empty};
    clr_st = rd && bus.address_i == ADDR_STATUS;
    clr_dr = rd && bus.address_i == ADDR_DROPS;
    unf_set = rd && is_pop && |(sel & empty);
    ndrops = 2'(drop[0]) + 2'(drop[1]) + 2'(drop[2]);
    drop_sum = {1'b0, drop_q} + 9'(ndrops);
    ovf_d = |drop ? 1'b1 : clr_st ? 1'b0 : ovf_q;
    unf_d = unf_set ? 1'b1 : clr_st ? 1'b0 : unf_q;
    drop_d = clr_dr ? 8'(ndrops) : drop_sum[8] ? 8'hFF : drop_sum[7:0];
    rdata_d = !rd ? rdata_q : clr_st ? st : is_pop ? pop_byte : is_occ ? 8'(occ) : drop_q;
  end
  // registered read data, sticky bits, drop counter and irq
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rdata_q <= 8'h00;
      drop_q <= 8'h00;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      drop_q <= drop_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      irq_q <= |(~empty);
    end
  assign bus.readdata_o = rdata_q;
  assign bus.eg_irq_o = irq_q;
endmodule
